// File: rtl/y86_execute_64_if.sv
// Decode-to-execute bundle for the Y86-64 execute stage: operands and
// condition codes in, ALU result, branch condition and flag register out.
interface y86_execute_64_if;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [2:0]  cndnflagin;
  logic [2:0]  cndnflagout;
  logic [63:0] valE;
  logic        cndn;

  modport master (
    output icode, ifun, valA, valB, valC, cndnflagin,
    input  cndnflagout, valE, cndn
  );

  modport slave (
    input  icode, ifun, valA, valB, valC, cndnflagin,
    output cndnflagout, valE, cndn
  );
endinterface

// File: rtl/y86_execute_64.sv
// Y86-64 SEQ execute stage: combinational valE/cndn plus the OPq condition-code register.
// Optional EXEC_INVALID_ICODE_EN adds an instr_err output flagging undefined icode/ifun.
module y86_execute_64 (
  input  logic              clk,
  input  logic              reset,
  y86_execute_64_if.slave   ex
`ifdef EXEC_INVALID_ICODE_EN
  ,
  output logic              instr_err
`endif
);

  logic [63:0] sum, diff, vale;
  logic        zf, sf, of;
  logic        opq_ok;
  logic        nzf, nsf, nof;
  logic        cnd;
  logic [2:0]  flags;

  assign sum    = ex.valB + ex.valA;
  assign diff   = ex.valB - ex.valA;
  assign opq_ok = (ex.icode == 4'h6) && (ex.ifun <= 4'd3);

  always_comb begin
    vale = '0;
    case (ex.icode)
      4'h2:       vale = ex.valA;
      4'h3:       vale = ex.valC;
      4'h4, 4'h5: vale = ex.valB + ex.valC;
      4'h6: begin
        case (ex.ifun)
          4'h0:    vale = sum;
          4'h1:    vale = diff;
          4'h2:    vale = ex.valB & ex.valA;
          4'h3:    vale = ex.valB ^ ex.valA;
          default: vale = '0;
        endcase
      end
      4'h8, 4'hA: vale = ex.valB - 64'd8;
      4'h9, 4'hB: vale = ex.valB + 64'd8;
      default:    vale = '0;
    endcase
  end

  assign ex.valE = vale;

  // Overflow is judged against B since B is the left operand of both add and sub.
  always_comb begin
    nzf = (vale == 64'd0);
    nsf = vale[63];
    nof = 1'b0;
    if (ex.ifun == 4'h0)
      nof = (ex.valA[63] == ex.valB[63]) && (vale[63] != ex.valB[63]);
    else if (ex.ifun == 4'h1)
      nof = (ex.valA[63] != ex.valB[63]) && (vale[63] != ex.valB[63]);
  end

  assign zf = ex.cndnflagin[0];
  assign sf = ex.cndnflagin[1];
  assign of = ex.cndnflagin[2];

  always_comb begin
    cnd = 1'b0;
    if (ex.icode == 4'h2 || ex.icode == 4'h7) begin
      case (ex.ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf ^ of) | zf;
        4'h2:    cnd = sf ^ of;
        4'h3:    cnd = zf;
        4'h4:    cnd = ~zf;
        4'h5:    cnd = ~(sf ^ of);
        4'h6:    cnd = ~(sf ^ of) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign ex.cndn = cnd;

  always_ff @(posedge clk) begin
    if (reset)
      flags <= 3'b000;
    else if (opq_ok)
      flags <= {nof, nsf, nzf};
  end

  assign ex.cndnflagout = flags;

`ifdef EXEC_INVALID_ICODE_EN
  assign instr_err = (ex.icode > 4'hB) || ((ex.icode == 4'h6) && (ex.ifun > 4'd3));
`endif

endmodule

// File: tb/tb_y86_execute_64.sv
// Directed bench for y86_execute_64: expectations queued at drive time, popped
// and checked against valE/cndn mid-cycle and against the flag register after the edge.
module tb_y86_execute_64;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
`ifdef EXEC_INVALID_ICODE_EN
  logic instr_err;
`endif

  typedef struct {
    logic [63:0] vale;
    logic        cndn;
    logic [2:0]  flags;
  } exp_t;

  exp_t sb[$];

  y86_execute_64_if bus ();

  y86_execute_64 dut (
    .clk       (clk),
    .reset     (reset),
    .ex        (bus)
`ifdef EXEC_INVALID_ICODE_EN
    ,
    .instr_err (instr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec condition table, indexed by ifun with flags {OF,SF,ZF}.
  function automatic logic cond_model(input logic [3:0] fn, input logic [2:0] f);
    logic z, s, o;
    z = f[0]; s = f[1]; o = f[2];
    case (fn)
      4'd0: return 1'b1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle of stimulus, then check comb outputs and the flags after the edge.
  task automatic apply(input string tag, input logic rst, input logic [3:0] ic,
                       input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [2:0] fin,
                       input logic [63:0] e_vale, input logic e_cndn, input logic [2:0] e_fl);
    exp_t e;
    @(negedge clk);
    reset = rst;
    bus.icode = ic; bus.ifun = fn;
    bus.valA = a; bus.valB = b; bus.valC = c;
    bus.cndnflagin = fin;
    sb.push_back('{e_vale, e_cndn, e_fl});
    #1;
    e = sb.pop_front();
    n_assert++;
    assert (bus.valE === e.vale) else begin
      n_fail++;
      $error("FAIL %s valE got %h want %h", tag, bus.valE, e.vale);
    end
    n_assert++;
    assert (bus.cndn === e.cndn) else begin
      n_fail++;
      $error("FAIL %s cndn got %b want %b", tag, bus.cndn, e.cndn);
    end
    @(posedge clk);
    #1;
    n_assert++;
    assert (bus.cndnflagout === e.flags) else begin
      n_fail++;
      $error("FAIL %s flags got %b want %b", tag, bus.cndnflagout, e.flags);
    end
  endtask

  initial begin
    logic [63:0] r;
    logic [2:0]  fl;
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.icode = 4'h0; bus.ifun = 4'h0;
    bus.valA = '0; bus.valB = '0; bus.valC = '0; bus.cndnflagin = 3'b000;
    @(posedge clk);
    #1;
    n_assert++;
    assert (bus.cndnflagout === 3'b000) else begin
      n_fail++;
      $error("FAIL reset flags got %b want 000", bus.cndnflagout);
    end

    apply("cmove_f0",  0, 4'h2, 4'h3, 64'd5, 64'd0, 64'h11, 3'b000, 64'd5, 1'b0, 3'b000);
    apply("cmove_f1",  0, 4'h2, 4'h3, 64'd5, 64'd0, 64'h11, 3'b001, 64'd5, 1'b1, 3'b000);
    apply("add_5_3",   0, 4'h6, 4'h0, 64'd5, 64'd3, 64'd0, 3'b000, 64'd8, 1'b0, 3'b000);
    apply("sub_zero",  0, 4'h6, 4'h1, 64'd8, 64'd8, 64'd0, 3'b000, 64'd0, 1'b0, 3'b001);
    apply("je_taken",  0, 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 3'b001, 64'd0, 1'b1, 3'b001);
    apply("add_ovf",   0, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
          64'd0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b110);
    apply("popq",      0, 4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 3'b000, 64'h108, 1'b0, 3'b110);
    apply("pushq",     0, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 3'b000, 64'hF8, 1'b0, 3'b110);
    apply("rmmovq",    0, 4'h4, 4'h0, 64'd0, 64'h20, 64'h11, 3'b000, 64'h31, 1'b0, 3'b110);
    apply("mrmovq",    0, 4'h5, 4'h0, 64'd7, 64'h20, 64'h11, 3'b000, 64'h31, 1'b0, 3'b110);
    apply("irmovq",    0, 4'h3, 4'h0, 64'd7, 64'd9, 64'hDEAD_BEEF, 3'b000, 64'hDEAD_BEEF, 1'b0, 3'b110);
    apply("call",      0, 4'h8, 4'h0, 64'd0, 64'h4, 64'd0, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 3'b110);
    apply("ret",       0, 4'h9, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 3'b000, 64'd0, 1'b0, 3'b110);
    apply("sub_ovf",   0, 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 3'b000,
          64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b100);
    apply("sub_neg",   0, 4'h6, 4'h1, 64'd5, 64'd3, 64'd0, 3'b000,
          64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b010);
    apply("and",       0, 4'h6, 4'h2, 64'hF0, 64'hFF, 64'd0, 3'b000, 64'hF0, 1'b0, 3'b000);
    apply("and_neg",   0, 4'h6, 4'h2, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
          64'd0, 3'b000, 64'h8000_0000_0000_0001, 1'b0, 3'b010);
    apply("xor_zero",  0, 4'h6, 4'h3, 64'h55, 64'h55, 64'd0, 3'b000, 64'd0, 1'b0, 3'b001);
    apply("opq_bad",   0, 4'h6, 4'h4, 64'd1, 64'd2, 64'd0, 3'b000, 64'd0, 1'b0, 3'b001);
    apply("icode_c",   0, 4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 3'b111, 64'd0, 1'b0, 3'b001);
    apply("halt",      0, 4'h0, 4'h0, 64'd1, 64'd2, 64'd3, 3'b111, 64'd0, 1'b0, 3'b001);
    apply("nop",       0, 4'h1, 4'h0, 64'd1, 64'd2, 64'd3, 3'b111, 64'd0, 1'b0, 3'b001);
    apply("opq_nocnd", 0, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 3'b001, 64'd0, 1'b0, 3'b001);

    // Reset must win over a flag-setting OPq in the same cycle.
    apply("sub_set",   0, 4'h6, 4'h1, 64'd8, 64'd8, 64'd0, 3'b000, 64'd0, 1'b0, 3'b001);
    apply("rst_opq",   1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 3'b000, 64'd0, 1'b0, 3'b000);
    apply("sub_set2",  0, 4'h6, 4'h1, 64'd8, 64'd8, 64'd0, 3'b000, 64'd0, 1'b0, 3'b001);
    apply("hold_2",    0, 4'h2, 4'h0, 64'd9, 64'd0, 64'd0, 3'b000, 64'd9, 1'b1, 3'b001);
    apply("hold_7",    0, 4'h7, 4'h0, 64'd9, 64'd0, 64'd0, 3'b000, 64'd0, 1'b1, 3'b001);
    apply("hold_9",    0, 4'h9, 4'h0, 64'd0, 64'h40, 64'd0, 3'b000, 64'h48, 1'b0, 3'b001);

    // Full condition table for cmovXX and jXX; flag register holds 001 throughout.
    fl = 3'b001;
    for (int ic = 0; ic < 2; ic++) begin
      for (int fn = 0; fn < 16; fn++) begin
        for (int f = 0; f < 8; f++) begin
          r = {$urandom, $urandom};
          apply(ic == 0 ? "cond_cmov" : "cond_jxx", 0, ic == 0 ? 4'h2 : 4'h7,
                4'(fn), r, 64'd0, 64'd0, 3'(f),
                ic == 0 ? r : 64'd0, cond_model(4'(fn), 3'(f)), fl);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
